// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Packs decoded instruction fields into 32-bit words
// (ALUop[31:29] rs1[28:24] rs2[23:19] rd[18:14] imm[13:0]) and writes them to
// consecutive instruction-memory addresses starting at BASE_ADDR.
//
// State table:
//   IDLE   | waiting for start; results of the last session are held
//   ACCEPT | in_ready high, waiting for a field bundle
//   WRITE  | mem_we high, word and address held until mem_ready
//   DONE   | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   start                           begin a session (only honoured in IDLE)
//   in_valid/in_ready               field bundle handshake
//   alu_op, rs1, rs2, rd, imm, last bundle contents
//   mem_we/mem_ready                memory write handshake
//   mem_addr, mem_wdata             write address and encoded word
//   busy, done                      session status, end-of-session pulse
//   word_count                      words written this session
//   imm_err, err_addr               sticky immediate range error, first bad address
//   overflow                        sticky: memory filled before last
module instr_encoder_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            alu_op,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [4:0]            rd,
    input  logic [31:0]           imm,
    input  logic                  last,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  imm_err,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   last_q;
    logic   imm_ok;

    // 14-bit signed range: every bit above the encoded sign bit matches it.
    assign imm_ok = (&imm[31:13]) | ~(|imm[31:13]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Handshake outputs decode straight from the state register so that an
    // asynchronous reset drops mem_we without waiting for a clock edge.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ACCEPT;
            end
            ACCEPT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_nxt = WRITE;
            end
            WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                if (mem_ready) begin
                    if (last_q || (mem_addr == ADDR_MAX)) state_nxt = DONE;
                    else                                  state_nxt = ACCEPT;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr   <= BASE;
            mem_wdata  <= '0;
            last_q     <= 1'b0;
            word_count <= '0;
            imm_err    <= 1'b0;
            err_addr   <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr   <= BASE;
                        word_count <= '0;
                        imm_err    <= 1'b0;
                        err_addr   <= '0;
                        overflow   <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        mem_wdata <= {alu_op, rs1, rs2, rd, imm[13:0]};
                        last_q    <= last;
                        // mem_addr already holds this word's address here.
                        if (!imm_ok) begin
                            imm_err <= 1'b1;
                            if (!imm_err) err_addr <= mem_addr;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        word_count <= word_count + 1'b1;
                        if (!last_q) begin
                            if (mem_addr == ADDR_MAX) overflow <= 1'b1;
                            else                      mem_addr <= mem_addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed testbench for instr_encoder_loader. dut uses the default geometry
// (ADDR_WIDTH=8, BASE_ADDR=0); dut2 uses ADDR_WIDTH=2 for the overflow case.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  alu_op = '0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [31:0] imm = '0;
    logic        last = 1'b0;

    logic        start = 1'b0, in_valid = 1'b0, mem_ready = 1'b0;
    logic        in_ready, mem_we, busy, done, imm_err, overflow;
    logic [7:0]  mem_addr, err_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  word_count;

    logic        start2 = 1'b0, in_valid2 = 1'b0, mem_ready2 = 1'b0;
    logic        in_ready2, mem_we2, busy2, done2, imm_err2, overflow2;
    logic [1:0]  mem_addr2, err_addr2;
    logic [31:0] mem_wdata2;
    logic [2:0]  word_count2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .last(last),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .word_count(word_count), .imm_err(imm_err),
        .err_addr(err_addr), .overflow(overflow)
    );

    instr_encoder_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
        .alu_op(alu_op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .last(last),
        .mem_we(mem_we2), .mem_ready(mem_ready2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .busy(busy2), .done(done2), .word_count(word_count2), .imm_err(imm_err2),
        .err_addr(err_addr2), .overflow(overflow2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one bundle to dut; returns one sample point after the handshake.
    task automatic send(input logic [2:0] a, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] d, input logic [31:0] im, input logic l);
        int n;
        alu_op = a; rs1 = r1; rs2 = r2; rd = d; imm = im; last = l;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_word_count", 32'(word_count), 0);
        check("rst_flags", {29'd0, imm_err, overflow, 1'b0}, 0);
        check("rst_err_addr", 32'(err_addr), 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // ADDI encode
        mem_ready = 1'b1;
        pulse_start();
        check("addi_busy", 32'(busy), 1);
        check("addi_in_ready", 32'(in_ready), 1);
        send(3'b110, 5'd3, 5'd0, 5'd5, 32'hFFFF_FFFF, 1'b1);
        check("addi_we", 32'(mem_we), 1);
        check("addi_not_ready", 32'(in_ready), 0);
        check("addi_addr", 32'(mem_addr), 0);
        check("addi_data", mem_wdata, 32'hC301_7FFF);
        tick();
        check("addi_done", 32'(done), 1);
        check("addi_busy_end", 32'(busy), 0);
        check("addi_count", 32'(word_count), 1);
        check("addi_imm_err", 32'(imm_err), 0);
        tick();
        check("addi_done_1cyc", 32'(done), 0);
        check("addi_count_hold", 32'(word_count), 1);

        // Immediate boundaries
        pulse_start();
        send(3'b000, 5'd0, 5'd0, 5'd0, 32'd8191, 1'b0);
        check("b0_addr", 32'(mem_addr), 0);
        check("b0_data", mem_wdata, 32'h0000_1FFF);
        check("b0_err", 32'(imm_err), 0);
        tick();
        send(3'b001, 5'd1, 5'd2, 5'd0, -32'sd8192, 1'b0);
        check("b1_addr", 32'(mem_addr), 1);
        check("b1_data", mem_wdata, 32'h2110_2000);
        check("b1_err", 32'(imm_err), 0);
        tick();
        send(3'b000, 5'd0, 5'd0, 5'd0, 32'd8192, 1'b1);
        check("b2_addr", 32'(mem_addr), 2);
        check("b2_data", mem_wdata, 32'h0000_2000);
        tick();
        check("b2_done", 32'(done), 1);
        check("b2_imm_err", 32'(imm_err), 1);
        check("b2_err_addr", 32'(err_addr), 2);
        check("b2_count", 32'(word_count), 3);
        tick();
        check("b2_err_hold", 32'(imm_err), 1);

        // Back-pressure, start during WRITE and ACCEPT; flags cleared by new start
        pulse_start();
        check("s2_clear_err", 32'(imm_err), 0);
        check("s2_clear_err_addr", 32'(err_addr), 0);
        check("s2_base_addr", 32'(mem_addr), 0);
        check("s2_clear_count", 32'(word_count), 0);
        mem_ready = 1'b0;
        send(3'b010, 5'd7, 5'd8, 5'd9, 32'd100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            check("bp_we", 32'(mem_we), 1);
            check("bp_addr", 32'(mem_addr), 0);
            check("bp_data", mem_wdata, 32'h4742_4064);
            check("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        start = 1'b0;
        check("bp_count_held", 32'(word_count), 0);
        mem_ready = 1'b1;
        tick();
        check("bp_count", 32'(word_count), 1);
        check("bp_next_addr", 32'(mem_addr), 1);
        check("bp_ready_back", 32'(in_ready), 1);
        pulse_start();
        check("st_acc_addr", 32'(mem_addr), 1);
        check("st_acc_count", 32'(word_count), 1);
        check("st_acc_ready", 32'(in_ready), 1);
        send(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
        check("bp2_addr", 32'(mem_addr), 1);
        tick();
        check("bp2_done", 32'(done), 1);
        check("bp2_count", 32'(word_count), 2);
        tick();

        // Reset mid-write
        pulse_start();
        send(3'b011, 5'd1, 5'd1, 5'd1, 32'd1, 1'b0);
        tick();
        mem_ready = 1'b0;
        send(3'b011, 5'd2, 5'd2, 5'd2, 32'd2, 1'b0);
        check("mr_we_before", 32'(mem_we), 1);
        check("mr_addr_before", 32'(mem_addr), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_we", 32'(mem_we), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_addr", 32'(mem_addr), 0);
        check("mr_count", 32'(word_count), 0);
        check("mr_wdata", mem_wdata, 0);
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        tick();
        pulse_start();
        send(3'b101, 5'd31, 5'd31, 5'd31, 32'h1FFF, 1'b1);
        check("mr_new_addr", 32'(mem_addr), 0);
        check("mr_new_data", mem_wdata, 32'hBFFF_DFFF);
        tick();
        check("mr_new_done", 32'(done), 1);
        check("mr_new_count", 32'(word_count), 1);

        // Overflow on the 4-word instance
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        mem_ready2 = 1'b1;
        last = 1'b0; imm = 32'd0; alu_op = '0; rs1 = '0; rs2 = '0;
        for (int i = 0; i < 4; i++) begin
            check("ovf_ready", 32'(in_ready2), 1);
            rd = 5'(i);
            in_valid2 = 1'b1;
            tick();
            in_valid2 = 1'b0;
            check("ovf_we", 32'(mem_we2), 1);
            check("ovf_addr", 32'(mem_addr2), i);
            check("ovf_data", mem_wdata2, i << 14);
            tick();
        end
        check("ovf_done", 32'(done2), 1);
        check("ovf_flag", 32'(overflow2), 1);
        check("ovf_count", 32'(word_count2), 4);
        check("ovf_busy", 32'(busy2), 0);
        in_valid2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ovf_no_accept", 32'(in_ready2), 0);
            check("ovf_no_write", 32'(mem_we2), 0);
        end
        in_valid2 = 1'b0;
        check("ovf_count_hold", 32'(word_count2), 4);
        check("ovf_addr_hold", 32'(mem_addr2), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
